btb_update_tx: RTL and testbench

- Transmitter side of the commit-to-BTB update interface: accepts retired control-flow instructions from the ROB commit port and drives one `rob_to_btb_bus` update per cycle toward the BTB/gshare predictor.
- Buffers updates in a small FIFO so commit never waits on predictor training, and holds them while the predictor is frozen.
- Sits between the ROB commit stage and the BTB.

---
 rtl/rv32i_types.sv | 31 +++
 rtl/btb_update_tx_if.sv | 33 +++
 rtl/btb_upd_fifo.sv | 59 +++++
 rtl/btb_update_tx.sv | 108 ++++++++++
 tb/tb_btb_update_tx.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I core types used by the commit-to-BTB update path.
//   GSHARE_DEPTH_BITS : width of the gshare index carried with each update
//   BTB_UPD_DEPTH     : default depth of the commit-side update queue
//   rob_to_btb_bus    : update bus from commit toward the BTB/gshare predictor
//   btb_upd_entry_t   : queued update (bus payload, plus mispredict bit when
//                       BTB_UPDATE_PERF_EN is defined)
package rv32i_types;

   localparam int GSHARE_DEPTH_BITS = 10;
   localparam int BTB_UPD_DEPTH     = 8;

   typedef struct packed {
      logic                         valid;
      logic                         ready;
      logic [31:0]                  pc;
      logic [31:0]                  pred_branch_address;
      logic                         branch_inst;
      logic                         jal_inst;
      logic                         branch_resol;
      logic                         branch_update;
      logic [GSHARE_DEPTH_BITS-1:0] gshare_index;
   } rob_to_btb_bus;

   typedef struct packed {
      rob_to_btb_bus bus;
`ifdef BTB_UPDATE_PERF_EN
      logic          mispredict;
`endif
   } btb_upd_entry_t;

endpackage

// File: rtl/btb_update_tx_if.sv
// Commit-port handshake between the ROB commit stage and btb_update_tx.
// Handshake: a retirement transfers on a rising clk edge where commit_valid
// and commit_ready are both high; commit_* payload must be stable while
// commit_valid is high, and commit_ready may depend combinationally on state
// but never on commit_valid.
//   master : ROB side (drives commit_*; receives commit_ready)
//   slave  : update transmitter side
interface btb_update_tx_if;
   import rv32i_types::*;

   logic                         commit_valid;
   logic                         commit_ready;
   logic [31:0]                  commit_pc;
   logic [31:0]                  commit_target;
   logic                         commit_br;
   logic                         commit_jal;
   logic                         commit_taken;
   logic                         commit_pred_taken;
   logic [GSHARE_DEPTH_BITS-1:0] commit_gshare_index;

   modport master (
      output commit_valid, commit_pc, commit_target, commit_br, commit_jal,
             commit_taken, commit_pred_taken, commit_gshare_index,
      input  commit_ready
   );

   modport slave (
      input  commit_valid, commit_pc, commit_target, commit_br, commit_jal,
             commit_taken, commit_pred_taken, commit_gshare_index,
      output commit_ready
   );

endinterface

// File: rtl/btb_upd_fifo.sv
// Generic synchronous FIFO with occupancy count.
//   clk, rst : clock, asynchronous active-low reset (pointers/count only)
//   push/din : enqueue; accepted when not full or when popping this cycle
//   pop/dout : dequeue head; ignored when empty; dout shows head entry
//   full, empty, count : occupancy status
module btb_upd_fifo #(
   parameter type T          = logic,
   parameter int  DEPTH      = 8,
   parameter int  DEPTH_BITS = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  T                    din,
   input  logic                pop,
   output T                    dout,
   output logic                full,
   output logic                empty,
   output logic [DEPTH_BITS:0] count
);

   localparam logic [DEPTH_BITS:0] FULL_CNT = DEPTH[DEPTH_BITS:0];

   T                      mem [DEPTH];
   logic [DEPTH_BITS-1:0] head;
   logic [DEPTH_BITS-1:0] tail;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A pop frees the slot at the same edge, so a full queue still accepts.
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[head];

   // Pointers wrap naturally: DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (do_push) tail <= tail + DEPTH_BITS'(1);
         if (do_pop)  head <= head + DEPTH_BITS'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (DEPTH_BITS+1)'(1);
            2'b01:   count <= count - (DEPTH_BITS+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[tail] <= din;
   end

endmodule

// File: rtl/btb_update_tx.sv
// Commit-to-BTB update transmitter. Retired branches/jals are packed into
// update entries and queued so commit never waits on predictor training;
// one update per cycle is driven toward the BTB unless btb_hold freezes it.
// Optional feature macro: BTB_UPDATE_PERF_EN adds saturating pop counters.
//   clk, rst      : clock, asynchronous active-low reset
//   cif (slave)   : commit handshake and retirement payload
//   btb_hold      : predictor frozen, no update issued
//   btb_out       : update bus (combinational from queue head)
//   q_count       : current queue occupancy
//   perf_*_cnt    : (BTB_UPDATE_PERF_EN) branch / jal / mispredict pops
module btb_update_tx
   import rv32i_types::*;
#(
   parameter int DEPTH      = BTB_UPD_DEPTH,
   parameter int DEPTH_BITS = $clog2(DEPTH),
   parameter int GHR_BITS   = GSHARE_DEPTH_BITS
) (
   input  logic                clk,
   input  logic                rst,
   btb_update_tx_if.slave      cif,
   input  logic                btb_hold,
   output rob_to_btb_bus       btb_out,
   output logic [DEPTH_BITS:0] q_count
`ifdef BTB_UPDATE_PERF_EN
   ,
   output logic [31:0]         perf_br_cnt,
   output logic [31:0]         perf_jal_cnt,
   output logic [31:0]         perf_mispred_cnt
`endif
);

   btb_upd_entry_t      new_e;
   btb_upd_entry_t      head_e;
   logic [GHR_BITS-1:0] gidx;
   logic                resol;
   logic                push;
   logic                pop;
   logic                fifo_full;
   logic                fifo_empty;

   assign gidx  = cif.commit_gshare_index;
   assign resol = cif.commit_jal ? 1'b1 : cif.commit_taken;
   assign pop   = !fifo_empty && !btb_hold;

   assign cif.commit_ready = !fifo_full || pop;
   // Non-control-flow retirements complete the handshake but are dropped.
   assign push = cif.commit_valid && cif.commit_ready &&
                 (cif.commit_br || cif.commit_jal);

   always_comb begin
      new_e                         = '0;
      new_e.bus.pc                  = cif.commit_pc;
      new_e.bus.pred_branch_address = cif.commit_target;
      // jal wins when both flags are set.
      new_e.bus.branch_inst         = cif.commit_br && !cif.commit_jal;
      new_e.bus.jal_inst            = cif.commit_jal;
      new_e.bus.branch_resol        = resol;
      new_e.bus.branch_update       = resol;
      new_e.bus.gshare_index        = gidx;
`ifdef BTB_UPDATE_PERF_EN
      new_e.mispredict              = (resol != cif.commit_pred_taken);
`endif
   end

   btb_upd_fifo #(
      .T          (btb_upd_entry_t),
      .DEPTH      (DEPTH),
      .DEPTH_BITS (DEPTH_BITS)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (new_e),
      .pop   (pop),
      .dout  (head_e),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (q_count)
   );

   // The BTB consumes every valid cycle, so valid and ready are identical.
   always_comb begin
      btb_out = '0;
      if (pop) begin
         btb_out       = head_e.bus;
         btb_out.valid = 1'b1;
         btb_out.ready = 1'b1;
      end
   end

`ifdef BTB_UPDATE_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_br_cnt      <= '0;
         perf_jal_cnt     <= '0;
         perf_mispred_cnt <= '0;
      end else if (pop) begin
         if (head_e.bus.branch_inst && (perf_br_cnt != '1))
            perf_br_cnt <= perf_br_cnt + 32'd1;
         if (head_e.bus.jal_inst && (perf_jal_cnt != '1))
            perf_jal_cnt <= perf_jal_cnt + 32'd1;
         if (head_e.mispredict && (perf_mispred_cnt != '1))
            perf_mispred_cnt <= perf_mispred_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_btb_update_tx.sv
// Self-checking bench for btb_update_tx: directed reset/filter/fill/full/
// async-reset sequences followed by random traffic with random btb_hold.
module tb_btb_update_tx;
   import rv32i_types::*;

   localparam int BW = $bits(rob_to_btb_bus);

   logic          clk;
   logic          rst;
   logic          btb_hold;
   rob_to_btb_bus btb_out;
   logic [3:0]    q_count;
`ifdef BTB_UPDATE_PERF_EN
   logic [31:0]   perf_br_cnt;
   logic [31:0]   perf_jal_cnt;
   logic [31:0]   perf_mispred_cnt;
`endif

   btb_update_tx_if cif();

   btb_update_tx dut (
      .clk      (clk),
      .rst      (rst),
      .cif      (cif),
      .btb_hold (btb_hold),
      .btb_out  (btb_out),
      .q_count  (q_count)
`ifdef BTB_UPDATE_PERF_EN
      ,
      .perf_br_cnt      (perf_br_cnt),
      .perf_jal_cnt     (perf_jal_cnt),
      .perf_mispred_cnt (perf_mispred_cnt)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [BW-1:0] exp_q[$];
   logic          mis_q[$];
   int            tests;
   int            failed;
   int            pop_cnt;
   int            m_br;
   int            m_jal;
   int            m_mis;
   logic          rand_phase;

   task automatic check(input string tag, input logic [127:0] got,
                        input logic [127:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic rob_to_btb_bus mk_exp(
      input logic [31:0] pc, input logic [31:0] tgt, input logic br,
      input logic jal, input logic taken,
      input logic [GSHARE_DEPTH_BITS-1:0] g);
      rob_to_btb_bus e;
      e                     = '0;
      e.valid               = 1'b1;
      e.ready               = 1'b1;
      e.pc                  = pc;
      e.pred_branch_address = tgt;
      e.branch_inst         = br & ~jal;
      e.jal_inst            = jal;
      e.branch_resol        = jal | taken;
      e.branch_update       = jal | taken;
      e.gshare_index        = g;
      return e;
   endfunction

   task automatic push_exp(input logic [31:0] pc, input logic [31:0] tgt,
                           input logic br, input logic jal, input logic taken,
                           input logic pred,
                           input logic [GSHARE_DEPTH_BITS-1:0] g);
      if (br || jal) begin
         exp_q.push_back(mk_exp(pc, tgt, br, jal, taken, g));
         mis_q.push_back((jal | taken) != pred);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [31:0] pc, input logic [31:0] tgt,
                        input logic br, input logic jal, input logic taken,
                        input logic pred,
                        input logic [GSHARE_DEPTH_BITS-1:0] g);
      cif.commit_valid        = 1'b1;
      cif.commit_pc           = pc;
      cif.commit_target       = tgt;
      cif.commit_br           = br;
      cif.commit_jal          = jal;
      cif.commit_taken        = taken;
      cif.commit_pred_taken   = pred;
      cif.commit_gshare_index = g;
   endtask

   // Drives one retirement and holds it until the handshake completes.
   // Returns #1 after the accepting edge.
   task automatic commit_tx(input logic [31:0] pc, input logic [31:0] tgt,
                            input logic br, input logic jal,
                            input logic taken, input logic pred,
                            input logic [GSHARE_DEPTH_BITS-1:0] g);
      bit ok;
      ok = 1'b0;
      drive(pc, tgt, br, jal, taken, pred, g);
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (cif.commit_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         check("commit_timeout", 0, 1);
         cif.commit_valid = 1'b0;
      end else begin
         push_exp(pc, tgt, br, jal, taken, pred, g);
         @(posedge clk);
         #1;
         cif.commit_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !btb_out.valid) begin
            ok = 1'b1;
            break;
         end
      end
      check("drain_done", ok, 1);
      check("drain_q_count", q_count, 0);
      @(posedge clk);
      #1;
   endtask

   // ---------------- output monitor ----------------
   always @(negedge clk) begin
      if (rst) begin
         if (btb_hold) check("hold_no_valid", btb_out.valid, 0);
         if (btb_out.valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", btb_out, 0);
            end else begin
               logic [BW-1:0] e;
               logic          m;
               e = exp_q.pop_front();
               m = mis_q.pop_front();
               check("btb_out", btb_out, e);
               pop_cnt++;
               if (e[BW-1-2-64])     m_br++;
               if (e[BW-1-2-64-1])   m_jal++;
               if (m)                m_mis++;
            end
         end else begin
            check("idle_zero", btb_out, 0);
         end
      end
   end

   // Random btb_hold during the random phase; changes only just after posedge.
   always @(posedge clk) begin
      if (rand_phase) begin
         #1;
         btb_hold = ($urandom_range(0, 3) == 0);
      end
   end

   task automatic check_perf(input string tag);
`ifdef BTB_UPDATE_PERF_EN
      check({tag, "_perf_br"},  perf_br_cnt,      m_br);
      check({tag, "_perf_jal"}, perf_jal_cnt,     m_jal);
      check({tag, "_perf_mis"}, perf_mispred_cnt, m_mis);
`endif
      if (tag == "") $display("[TB] empty perf tag");
   endtask

   // ---------------- main sequence ----------------
   initial begin
      tests      = 0;
      failed     = 0;
      pop_cnt    = 0;
      m_br       = 0;
      m_jal      = 0;
      m_mis      = 0;
      rand_phase = 1'b0;
      btb_hold   = 1'b0;
      cif.commit_valid        = 1'b0;
      cif.commit_pc           = '0;
      cif.commit_target       = '0;
      cif.commit_br           = 1'b0;
      cif.commit_jal          = 1'b0;
      cif.commit_taken        = 1'b0;
      cif.commit_pred_taken   = 1'b0;
      cif.commit_gshare_index = '0;
      rst = 1'b0;

      // Reset state
      #12;
      check("rst_valid",        btb_out.valid,    0);
      check("rst_bus_zero",     btb_out,          0);
      check("rst_q_count",      q_count,          0);
      check("rst_commit_ready", cif.commit_ready, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // First taken branch: no bypass, appears one cycle after acceptance
      drive(32'h1000, 32'h1040, 1'b1, 1'b0, 1'b1, 1'b1, 10'h05A);
      @(negedge clk);
      check("first_ready",     cif.commit_ready, 1);
      check("first_no_bypass", btb_out.valid,    0);
      push_exp(32'h1000, 32'h1040, 1'b1, 1'b0, 1'b1, 1'b1, 10'h05A);
      @(posedge clk);
      #1;
      cif.commit_valid = 1'b0;
      check("first_valid",   btb_out.valid,               1);
      check("first_pc",      btb_out.pc,                  32'h1000);
      check("first_tgt",     btb_out.pred_branch_address, 32'h1040);
      check("first_br",      btb_out.branch_inst,         1);
      check("first_resol",   btb_out.branch_resol,        1);
      check("first_update",  btb_out.branch_update,       1);
      check("first_q_count", q_count,                     1);
      wait_drain();

      // Filtering of non-control-flow retirements
      drive(32'h1800, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 10'h0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("filt_q_count", q_count,          0);
         check("filt_ready",   cif.commit_ready, 1);
         @(posedge clk);
         #1;
      end
      cif.commit_valid = 1'b0;
      // jal with commit_taken=0 still resolves taken
      commit_tx(32'h2000, 32'h2400, 1'b0, 1'b1, 1'b0, 1'b0, 10'h111);
      // br+jal together is treated as jal
      commit_tx(32'h2004, 32'h2800, 1'b1, 1'b1, 1'b0, 1'b1, 10'h222);
      wait_drain();

      // Fill under hold, then drain in order
      btb_hold = 1'b1;
      for (int i = 0; i < 8; i++)
         commit_tx(32'h100 + 32'(4 * i), 32'h4000 + 32'(i), 1'b1, 1'b0,
                   i[0], 1'b0, 10'(i));
      @(negedge clk);
      check("fill_q_count", q_count,          8);
      check("fill_ready",   cif.commit_ready, 0);
      @(posedge clk);
      #1;
      pop_cnt  = 0;
      btb_hold = 1'b0;
      wait_drain();
      check("fill_pop_cnt", pop_cnt, 8);

      // Full with concurrent pop
      btb_hold = 1'b1;
      for (int i = 0; i < 8; i++)
         commit_tx(32'h300 + 32'(4 * i), 32'h5000, 1'b1, 1'b0, 1'b1,
                   1'b1, 10'(i + 16));
      @(posedge clk);
      #1;
      btb_hold = 1'b0;
      commit_tx(32'h200, 32'h6000, 1'b1, 1'b0, 1'b0, 1'b0, 10'h3FF);
      check("full_pop_q_count", q_count, 8);
      wait_drain();

      // Asynchronous reset with entries queued
      btb_hold = 1'b1;
      for (int i = 0; i < 3; i++)
         commit_tx(32'h700 + 32'(4 * i), 32'h7000, 1'b0, 1'b1, 1'b1,
                   1'b1, 10'h0);
      @(posedge clk);
      #1;
      btb_hold = 1'b0;
      #1;
      check("pre_arst_valid", btb_out.valid, 1);
      #1;
      rst = 1'b0;
      #1;
      check("arst_valid",   btb_out.valid,    0);
      check("arst_q_count", q_count,          0);
      check("arst_ready",   cif.commit_ready, 1);
      exp_q.delete();
      mis_q.delete();
      m_br  = 0;
      m_jal = 0;
      m_mis = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Perf mix: 3 branches (one mispredicted) + 2 jals
      commit_tx(32'h800, 32'h900, 1'b1, 1'b0, 1'b1, 1'b1, 10'h1);
      commit_tx(32'h804, 32'h904, 1'b1, 1'b0, 1'b0, 1'b1, 10'h2);
      commit_tx(32'h808, 32'h908, 1'b0, 1'b1, 1'b0, 1'b1, 10'h3);
      commit_tx(32'h80C, 32'h90C, 1'b1, 1'b0, 1'b0, 1'b0, 10'h4);
      commit_tx(32'h810, 32'h910, 1'b0, 1'b1, 1'b1, 1'b1, 10'h5);
      wait_drain();
      check("mix_model_br",  m_br,  3);
      check("mix_model_jal", m_jal, 2);
      check("mix_model_mis", m_mis, 1);
      check_perf("mix");

      // Random traffic with random hold
      rand_phase = 1'b1;
      for (int i = 0; i < 60; i++) begin
         commit_tx($urandom, $urandom, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)),
                   10'($urandom_range(0, 1023)));
      end
      rand_phase = 1'b0;
      @(posedge clk);
      #2;
      btb_hold = 1'b0;
      wait_drain();
      check_perf("rand");

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   // Global time limit.
   initial begin
      #200000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
